// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and FSM state encoding for the seven-segment scan driver.
package seg_pkg;

    // Legal range for the number of multiplexed digits.
    localparam int unsigned SEG_MIN_DIGITS = 2;
    localparam int unsigned SEG_MAX_DIGITS = 8;

    // Active-low pattern with every segment off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Scan FSM: all-off guard gap, then the selected digit lit.
    typedef enum logic {
        StGuard = 1'b0,
        StOn    = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: BCD nibble to active-low segments a..g (bits 6..0).
// Codes 10..15 decode to all-off and are flagged invalid.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o,
    output logic       valid_o
);

    // Pure lookup; defaults cover the non-BCD codes.
    always_comb begin
        seg_o   = SEG_BLANK;
        valid_o = 1'b1;
        case (nibble_i)
            4'd0:    seg_o = 7'b0000001;
            4'd1:    seg_o = 7'b1001111;
            4'd2:    seg_o = 7'b0010010;
            4'd3:    seg_o = 7'b0000110;
            4'd4:    seg_o = 7'b1001100;
            4'd5:    seg_o = 7'b0100100;
            4'd6:    seg_o = 7'b0100000;
            4'd7:    seg_o = 7'b0001111;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0000100;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment driver with per-frame input snapshot.
// Each digit slot is GUARD_CYCLES all-off followed by ON_CYCLES lit.
// Optional blinking is built only when SEG_SCAN_BLINK_EN is defined.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned ON_CYCLES    = 50000,
    parameter int unsigned GUARD_CYCLES = 500,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
    localparam int unsigned CntMax = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);
    localparam logic [CntW-1:0] OnLast    = CntW'(ON_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < SEG_MIN_DIGITS || NUM_DIGITS > SEG_MAX_DIGITS ||
        GUARD_CYCLES < 1 || GUARD_CYCLES > 65535 || ON_CYCLES < 1) begin : g_bad_params
        $error("seg_scan_driver: parameter out of range");
    end

    scan_state_e             state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_start_q, frame_start_d;

    logic       capture;
    logic [3:0] nibble;
    logic [6:0] dec_seg;
    logic       dec_valid;
    logic       blink_dark;
    logic       digit_dark;

    // Snapshot is taken exactly once per frame: first GUARD cycle of digit 0.
    assign capture = (state_q == StGuard) && (idx_q == '0) && (cnt_q == '0);

    // Slot sequencer: GUARD then ON per digit, index wraps after the last digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            StGuard: begin
                if (cnt_q == GuardLast) begin
                    state_d = StOn;
                    cnt_d   = '0;
                end
            end
            StOn: begin
                if (cnt_q == OnLast) begin
                    state_d = StGuard;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = StGuard;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Snapshot next-state: hold except on the capture cycle.
    always_comb begin
        snap_digits_d = snap_digits_q;
        snap_blank_d  = snap_blank_q;
        snap_dp_d     = snap_dp_q;
        if (capture) begin
            snap_digits_d = digits;
            snap_blank_d  = blank_mask;
            snap_dp_d     = dp_mask;
        end
    end

    assign nibble = snap_digits_q[{idx_q, 2'b00} +: 4];

    seg_decoder u_seg_decoder (
        .nibble_i (nibble),
        .seg_o    (dec_seg),
        .valid_o  (dec_valid)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BfW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BfW-1:0]        frame_cnt_q, frame_cnt_d;
    logic                  phase_q, phase_d;
    logic [NUM_DIGITS-1:0] snap_blink_q, snap_blink_d;
    logic                  frame_end;

    assign frame_end = (state_q == StOn) && (cnt_q == OnLast) && (idx_q == IdxLast);

    // Blink phase flips after every BLINK_FRAMES completed frames.
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        snap_blink_d = capture ? blink_mask : snap_blink_q;
        if (frame_end) begin
            if (frame_cnt_q == BfW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
            snap_blink_q <= '0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            snap_blink_q <= snap_blink_d;
        end
    end

    assign blink_dark = phase_q & snap_blink_q[idx_q];
`else
    localparam int unsigned unused_blink_frames = BLINK_FRAMES;
    logic unused_blink_mask;
    assign unused_blink_mask = ^blink_mask;
    assign blink_dark        = 1'b0;
`endif

    // Non-BCD codes darken the whole digit, same as an explicit blank.
    assign digit_dark = snap_blank_q[idx_q] | ~dec_valid | blink_dark;

    // Pin values one cycle behind the sequencer; dark in GUARD and for dark digits.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_q == StOn && !digit_dark) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dec_seg;
            dp_d        = ~snap_dp_q[idx_q];
        end
    end

    assign frame_start_d = capture;

    // Sequencer, snapshot and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StGuard;
            idx_q         <= '0;
            cnt_q         <= '0;
            snap_digits_q <= '0;
            snap_blank_q  <= '0;
            snap_dp_q     <= '0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            snap_digits_q <= snap_digits_d;
            snap_blank_q  <= snap_blank_d;
            snap_dp_q     <= snap_dp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits, range 2..8.
REQ-002 SHALL have parameter ON_CYCLES, default 50000: clock cycles each digit is lit.
REQ-003 SHALL have parameter GUARD_CYCLES, default 500: all-off cycles between digits, range 1..65535.
REQ-004 SHALL have parameter BLINK_FRAMES, default 64: frames per blink half-period.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port digits, input, 4*NUM_DIGITS: BCD nibbles, digit k at [4k+3:4k], digit 0 rightmost.
REQ-008 SHALL have port blank_mask, input, NUM_DIGITS: 1 means the digit is suppressed.
REQ-009 SHALL have port dp_mask, input, NUM_DIGITS: 1 means the decimal point is lit.
REQ-010 SHALL have port blink_mask, input, NUM_DIGITS: 1 means the digit blinks (used only with the macro).
REQ-011 SHALL have port an, output, NUM_DIGITS: digit enables, active-low, one-hot-low or all-high.
REQ-012 SHALL have port seg, output, 7: segments a..g at bits 6..0, active-low.
REQ-013 SHALL have port dp, output, 1: decimal point, active-low.
REQ-014 SHALL have port frame_start, output, 1: one-cycle pulse when the snapshot is taken.

Function
REQ-015 SHALL run FSM states GUARD and ON; GUARD lasts GUARD_CYCLES cycles, then ON; ON lasts ON_CYCLES cycles, then GUARD with index+1.
REQ-016 SHALL wrap the digit index from NUM_DIGITS-1 to 0.
REQ-017 SHALL capture digits, blank_mask and dp_mask into a snapshot register on the first GUARD cycle of index 0, asserting frame_start that cycle.
REQ-018 SHALL drive all outputs from the snapshot only, so that input changes mid-frame never tear.
REQ-019 SHALL hold an all-ones, seg=7'b1111111 and dp=1 throughout GUARD.
REQ-020 SHALL in ON drive an[index]=0 (others 1), seg=decode(nibble), dp=~dp_mask[index].
REQ-021 SHALL use decode patterns (active-low) 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, and 10..15=1111111.
REQ-022 SHALL for a blanked digit in ON keep an[index]=1, seg all-ones and dp=1, with timing unchanged.
REQ-023 SHALL register all outputs, with 1-cycle latency from state/index change to pins.
REQ-024 SHALL give frame length NUM_DIGITS*(ON_CYCLES+GUARD_CYCLES) cycles exactly.

Reset
REQ-025 SHALL on rst_n low asynchronously force an all-ones, seg=7'b1111111, dp=1, frame_start=0, state GUARD, index 0, counters 0, snapshot 0, and blink phase 0.
REQ-026 SHALL after release start a full GUARD for index 0, with frame_start on the first clk edge.
REQ-027 SHALL when reset mid-ON turn the digit off immediately with no partial-frame resume.

Configuration
REQ-028 SHALL with macro SEG_SCAN_BLINK_EN defined snapshot blink_mask at frame_start, toggle the blink phase every BLINK_FRAMES frames, and blank blink_mask digits (per REQ-022) while phase=1.
REQ-029 SHALL without SEG_SCAN_BLINK_EN keep the blink_mask port, ignore it, and build no blink counter.

Structure
REQ-030 SHALL place seg_pkg constants for digit count limits, the 7-bit blank pattern SEG_BLANK=7'b1111111 and FSM state encoding in a shared package.
REQ-031 SHALL instantiate the existing seg_decoder as the sole sub-module for nibble-to-segment conversion.

Verification
REQ-032 SHALL with NUM_DIGITS=4, ON=4, GUARD=1 and digits=16'h1234 show an sequence 1110,1101,1011,0111, each low exactly 4 cycles, seg 1001100,0000110,0010010,1001111, and period 20 cycles.
REQ-033 SHALL when digits change 16'h1234->16'h5678 while index 2 is lit finish the frame with 1234, with 5678 seen from next frame_start.
REQ-034 SHALL with nibble=4'hA or blank_mask[1]=1 keep that slot with an all-ones and seg=1111111 while other slot timing is unchanged.
REQ-035 SHALL with dp_mask=4'b0100 drive dp=0 only while an=1011.
REQ-036 SHALL when rst_n pulses low during ON of index 3 set an=1111 the same cycle and, after release, make the first lit digit index 0 after exactly 1 GUARD cycle.
REQ-037 SHALL with SEG_SCAN_BLINK_EN, BLINK_FRAMES=2 and blink_mask=4'b0001 leave digit 0 lit for frames 0-1, dark for frames 2-3, and lit again for frame 4.
